// File: rtl/wave_capture.sv
// wave_capture
//   Captures one 256-sample window of the audio stream, starting at a positive
//   zero crossing, into the bank of the double-buffered waveform RAM that the
//   display is not reading. Once the window is full and the display reports
//   idle, read_index toggles so the fresh bank becomes the read bank.
//
// Ports
//   clk                system clock, rising edge
//   reset              asynchronous, active-low reset
//   new_sample_ready   one-cycle strobe qualifying new_sample_in
//   new_sample_in      signed audio sample
//   wave_display_idle  display is not reading RAM, bank swap allowed
//   notes_to_display   currently sounding notes (all-zero = silence)
//   write_address      RAM write address {~read_index, index}
//   write_enable       one-cycle RAM write strobe
//   write_sample       offset-binary top byte of the sample
//   read_index         bank read by the display
module wave_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 9,
    parameter int WRITE_WIDTH  = 8,
    parameter int NOTES_WIDTH  = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    input  logic [NOTES_WIDTH-1:0]  notes_to_display,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic                    write_enable,
    output logic [WRITE_WIDTH-1:0]  write_sample,
    output logic                    read_index
);

    typedef enum logic [1:0] {
        S_ARMED,
        S_ACTIVE,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-2:0]   count_q, count_d;
    logic [SAMPLE_WIDTH-1:0] prev_sample_q, prev_sample_d;
    logic                    read_index_q, read_index_d;
    logic                    write_enable_q, write_enable_d;
    logic [ADDR_WIDTH-1:0]   write_address_q, write_address_d;
    logic [WRITE_WIDTH-1:0]  write_sample_q, write_sample_d;

    logic pzc;
    logic notes_active;
    logic issue_write;
    logic swap;

    // Negative previous sample followed by a non-negative new one.
    assign pzc          = new_sample_ready & prev_sample_q[SAMPLE_WIDTH-1]
                          & ~new_sample_in[SAMPLE_WIDTH-1];
    assign notes_active = |notes_to_display;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_ARMED;
            count_q         <= '0;
            prev_sample_q   <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            prev_sample_q   <= prev_sample_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ARMED:  if (pzc && notes_active) state_d = S_ACTIVE;
            S_ACTIVE: if (new_sample_ready && (count_q == '1)) state_d = S_WAIT;
            S_WAIT:   if (wave_display_idle) state_d = S_ARMED;
            default:  state_d = S_ARMED;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        issue_write = ((state_q == S_ARMED) && pzc && notes_active)
                      || ((state_q == S_ACTIVE) && new_sample_ready);
        swap        = (state_q == S_WAIT) && wave_display_idle;

        prev_sample_d   = new_sample_ready ? new_sample_in : prev_sample_q;
        read_index_d    = swap ? ~read_index_q : read_index_q;
        write_enable_d  = issue_write;
        // count wraps to 0 naturally after index 255
        count_d         = issue_write ? count_q + 1'b1 : count_q;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        if (issue_write) begin
            write_address_d = {~read_index_q, count_q};
            write_sample_d  = {~new_sample_in[SAMPLE_WIDTH-1],
                               new_sample_in[SAMPLE_WIDTH-2 -: WRITE_WIDTH-1]};
        end
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture
//   Directed-vector bench for wave_capture: reset, crossing detection, window
//   fill, bank swap, silence gating and asynchronous abort.
module tb_wave_capture;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [47:0] notes_to_display;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int checks = 0;
    int errors = 0;

    wave_capture #(
        .SAMPLE_WIDTH(16),
        .ADDR_WIDTH  (9),
        .WRITE_WIDTH (8),
        .NOTES_WIDTH (48)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .wave_display_idle(wave_display_idle),
        .notes_to_display (notes_to_display),
        .write_address    (write_address),
        .write_enable     (write_enable),
        .write_sample     (write_sample),
        .read_index       (read_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe one sample, then check the registered write one cycle later.
    task automatic send(input string tag, input logic [15:0] s, input logic exp_we,
                        input logic [8:0] exp_addr, input logic [7:0] exp_data);
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        @(negedge clk);
        new_sample_ready = 1'b0;
        check({tag, ".we"}, {31'd0, write_enable}, {31'd0, exp_we});
        if (exp_we) begin
            check({tag, ".addr"}, {23'd0, write_address}, {23'd0, exp_addr});
            check({tag, ".data"}, {24'd0, write_sample}, {24'd0, exp_data});
        end
    endtask

    task automatic idle_pulse();
        @(negedge clk);
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
    endtask

    initial begin
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;
        notes_to_display  = '0;
        reset             = 1'b0;

        // 1. Reset held with toggling inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            new_sample_ready  = ~new_sample_ready;
            new_sample_in     = (i % 2 == 0) ? 16'h8001 : 16'h0001;
            wave_display_idle = ~wave_display_idle;
            notes_to_display  = 48'd24;
        end
        check("rst.we",   {31'd0, write_enable},  32'd0);
        check("rst.addr", {23'd0, write_address}, 32'd0);
        check("rst.data", {24'd0, write_sample},  32'd0);
        check("rst.ridx", {31'd0, read_index},    32'd0);
        @(negedge clk);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        new_sample_in     = '0;
        reset             = 1'b1;

        // 2. Crossing
        notes_to_display = 48'd24;
        send("x.neg", 16'hF0F0, 1'b0, 9'h000, 8'h00);
        send("x.pos", 16'h30F3, 1'b1, 9'h100, 8'hB0);
        send("x.nxt", 16'hF0F0, 1'b1, 9'h101, 8'h70);
        @(negedge clk);
        check("x.pulse", {31'd0, write_enable}, 32'd0);

        // idle is ignored while ACTIVE; notes going silent is ignored too
        wave_display_idle = 1'b1;
        notes_to_display  = '0;
        send("a.idle", 16'h0200, 1'b1, 9'h102, 8'h82);
        wave_display_idle = 1'b0;
        check("a.ridx", {31'd0, read_index}, 32'd0);

        // Back-to-back strobes at indices 3 and 4
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = 16'h8300;
        @(negedge clk);
        new_sample_in    = 16'h0400;
        check("b2b.we0",   {31'd0, write_enable},  32'd1);
        check("b2b.addr0", {23'd0, write_address}, 32'h103);
        check("b2b.data0", {24'd0, write_sample},  32'h03);
        @(negedge clk);
        new_sample_ready = 1'b0;
        check("b2b.we1",   {31'd0, write_enable},  32'd1);
        check("b2b.addr1", {23'd0, write_address}, 32'h104);
        check("b2b.data1", {24'd0, write_sample},  32'h84);

        // 3. Fill indices 5..255; sample top byte = index, data = index ^ 0x80
        for (int i = 5; i < 256; i++)
            send("fill", {i[7:0], 8'h55}, 1'b1, {1'b1, i[7:0]}, i[7:0] ^ 8'h80);
        send("wait.0", 16'h8000, 1'b0, 9'h000, 8'h00);
        send("wait.1", 16'h0001, 1'b0, 9'h000, 8'h00);
        check("wait.ridx", {31'd0, read_index}, 32'd0);

        // 4. Swap, with a sample arriving in the swap cycle (not written)
        @(negedge clk);
        wave_display_idle = 1'b1;
        new_sample_ready  = 1'b1;
        new_sample_in     = 16'h1234;
        @(negedge clk);
        wave_display_idle = 1'b0;
        new_sample_ready  = 1'b0;
        check("swap.ridx", {31'd0, read_index},   32'd1);
        check("swap.we",   {31'd0, write_enable}, 32'd0);

        // 5. Gating: silence blocks capture, then a real crossing writes bank 0
        notes_to_display = '0;
        send("g.neg0", 16'hFFFF, 1'b0, 9'h000, 8'h00);
        send("g.pos0", 16'h0001, 1'b0, 9'h000, 8'h00);
        notes_to_display = 48'd2467;
        send("g.neg1", 16'hFFFF, 1'b0, 9'h000, 8'h00);
        send("g.pos1", 16'h0001, 1'b1, 9'h000, 8'h80);
        for (int i = 1; i < 256; i++)
            send("fill0", {i[7:0], 8'hAA}, 1'b1, {1'b0, i[7:0]}, i[7:0] ^ 8'h80);
        send("wait0", 16'h8000, 1'b0, 9'h000, 8'h00);
        idle_pulse();
        check("swap0.ridx", {31'd0, read_index}, 32'd0);

        // 6. Async abort with the write for index 99 on the outputs (count = 100)
        send("ab.neg", 16'h8000, 1'b0, 9'h000, 8'h00);
        send("ab.pos", 16'h0100, 1'b1, 9'h100, 8'h81);
        for (int i = 1; i < 100; i++)
            send("ab.fill", {i[7:0], 8'h00}, 1'b1, {1'b1, i[7:0]}, i[7:0] ^ 8'h80);
        #2;
        reset = 1'b0;
        #1;
        check("ab.we",   {31'd0, write_enable},  32'd0);
        check("ab.addr", {23'd0, write_address}, 32'd0);
        check("ab.data", {24'd0, write_sample},  32'd0);
        check("ab.ridx", {31'd0, read_index},    32'd0);
        @(negedge clk);
        reset = 1'b1;
        send("re.neg", 16'hC000, 1'b0, 9'h000, 8'h00);
        send("re.pos", 16'h4000, 1'b1, 9'h100, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
